// File: rtl/uart_echo_requester.sv
// Echo-link requester: sends one 8N1 request byte, then receives the reply and checks it against request*2.
// done pulses one cycle after the reply stop-bit sample or on timeout; start is honoured only in IDLE.
module uart_echo_requester #(
    parameter int CLOCK_FREQ   = 27000000,
    parameter int BAUD_RATE    = 3000000,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  req_data,
    output logic        tx,
    input  logic        rx,
    output logic        busy,
    output logic        done,
    output logic [7:0]  resp_data,
    output logic        match,
    output logic        timeout,
    output logic        frame_error,
    output logic [15:0] err_count
);

    localparam int CPB     = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF    = CPB / 2;
    localparam int TMO_CYC = TIMEOUT_BITS * CPB;
    localparam int CW      = $clog2(CPB);
    localparam int TW      = $clog2(TMO_CYC + 1);

    typedef enum logic [2:0] {
        IDLE, TX_START, TX_DATA, TX_STOP, WAIT, RX_DATA, RX_STOP, REPORT
    } state_t;

    state_t        state, next_state;
    logic [CW-1:0] clk_cnt;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    tx_shift;
    logic [7:0]    rx_shift;
    logic [7:0]    expected;
    logic [TW-1:0] tmo_cnt;
    logic          qual;
    logic          rx_meta, rx_s;
    logic [15:0]   err_next;

    logic accept, bit_end, rx_tick, armed, confirm, tmo_hit;

    assign accept   = (state == IDLE) && start;
    assign bit_end  = (clk_cnt == '0);
    assign rx_tick  = (rx_cnt == '0);
    assign armed    = (state == TX_STOP) || (state == WAIT);
    assign confirm  = armed && qual && rx_tick && !rx_s;
    // A confirmed start bit wins over a timeout expiring in the same cycle.
    assign tmo_hit  = armed && !confirm && (tmo_cnt == '0);
    assign err_next = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) next_state = TX_START;
            end
            TX_START: if (bit_end) next_state = TX_DATA;
            TX_DATA:  if (bit_end && bit_idx == 3'd7) next_state = TX_STOP;
            TX_STOP: begin
                if (confirm)      next_state = RX_DATA;
                else if (tmo_hit) next_state = REPORT;
                else if (bit_end) next_state = WAIT;
            end
            WAIT: begin
                if (confirm)      next_state = RX_DATA;
                else if (tmo_hit) next_state = REPORT;
            end
            RX_DATA: if (rx_tick && bit_idx == 3'd7) next_state = RX_STOP;
            RX_STOP: if (rx_tick) next_state = REPORT;
            REPORT: begin
                busy       = 1'b0;
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta     <= 1'b1;
            rx_s        <= 1'b1;
            tx          <= 1'b1;
            tx_shift    <= '0;
            rx_shift    <= '0;
            expected    <= '0;
            clk_cnt     <= '0;
            rx_cnt      <= '0;
            bit_idx     <= '0;
            tmo_cnt     <= '0;
            qual        <= 1'b0;
            resp_data   <= '0;
            match       <= 1'b0;
            timeout     <= 1'b0;
            frame_error <= 1'b0;
            err_count   <= '0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            case (state)
                IDLE: begin
                    if (accept) begin
                        tx          <= 1'b0;
                        tx_shift    <= req_data;
                        expected    <= {req_data[6:0], 1'b0};
                        clk_cnt     <= CW'(CPB - 1);
                        bit_idx     <= '0;
                        qual        <= 1'b0;
                        match       <= 1'b0;
                        timeout     <= 1'b0;
                        frame_error <= 1'b0;
                    end
                end
                TX_START: begin
                    if (bit_end) begin
                        tx       <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        clk_cnt  <= CW'(CPB - 1);
                    end else begin
                        clk_cnt <= clk_cnt - CW'(1);
                    end
                end
                TX_DATA: begin
                    if (bit_end) begin
                        clk_cnt <= CW'(CPB - 1);
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            // Stop bit out; the receiver and timeout arm now.
                            tx      <= 1'b1;
                            tmo_cnt <= TW'(TMO_CYC);
                            qual    <= 1'b0;
                        end else begin
                            tx       <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                        end
                    end else begin
                        clk_cnt <= clk_cnt - CW'(1);
                    end
                end
                TX_STOP, WAIT: begin
                    if (!bit_end) clk_cnt <= clk_cnt - CW'(1);
                    if (!confirm && tmo_cnt != '0) tmo_cnt <= tmo_cnt - TW'(1);
                    if (!qual) begin
                        if (!rx_s) begin
                            qual   <= 1'b1;
                            rx_cnt <= CW'(HALF - 1);
                        end
                    end else if (rx_tick) begin
                        // Low at mid-start confirms; high means a glitch, re-arm.
                        qual <= 1'b0;
                        if (!rx_s) begin
                            rx_cnt  <= CW'(CPB - 1);
                            bit_idx <= '0;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - CW'(1);
                    end
                    if (tmo_hit) begin
                        timeout   <= 1'b1;
                        match     <= 1'b0;
                        err_count <= err_next;
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        rx_cnt   <= CW'(CPB - 1);
                        bit_idx  <= bit_idx + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt - CW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_tick) begin
                        resp_data   <= rx_shift;
                        frame_error <= !rx_s;
                        match       <= (rx_shift == expected);
                        if (!rx_s || rx_shift != expected) err_count <= err_next;
                    end else begin
                        rx_cnt <= rx_cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
